filter_voice_scheduler: RTL and testbench
=========================================

// Module: filter_voice_scheduler
// PURPOSE
// - Time-multiplexes one pipelined filter core (valid/ready in, tagged valid out) across N_CH audio channels.
// - On each sample_clk rising edge: snapshots all channel inputs, issues them to the core in channel order, collects tagged results, then commits every channel output in a single cycle.
// - Sits between the codec sample bus and the shared filter core; lets one multiplier-heavy core serve all jacks.
// PARAMETERS
// - W        16    sample / cutoff / resonance width, signed two's complement
// - N_CH     4     channels served per frame (>=2); CHW = $clog2(N_CH) is a localparam
// - TIMEOUT  1024  clk cycles from accepted edge to forced abort (>= N_CH + core latency + 2)
// PORTS
// - clk            in   1         system clock
// - rst_n          in   1         reset: synchronous, active-low
// - sample_clk     in   1         sample strobe, clk-synchronous level; rising edge starts a frame
// - ch_in          in   N_CH*W    packed channel samples, ch k at [k*W +: W]
// - ch_g           in   N_CH*W    packed per-channel cutoff
// - ch_res         in   N_CH*W    packed per-channel resonance
// - core_valid     out  1         issue request to core
// - core_ready     in   1         core accepts issue when valid & ready
// - core_ch        out  CHW       channel tag of issued job
// - core_sample    out  W         snapshot sample for core_ch
// - core_g         out  W         snapshot cutoff for core_ch
// - core_res       out  W         snapshot resonance for core_ch
// - core_out_valid in   1         core result strobe (one per accepted issue)
// - core_out_ch    in   CHW       tag of result
// - core_out       in   W         result sample
// - ch_out         out  N_CH*W    packed committed outputs
// - frame_done     out  1         1-cycle pulse, coincident with ch_out update
// - busy           out  1         high in ISSUE or DRAIN
// - overrun        out  1         sticky: edge arrived while busy
// - timeout_err    out  1         sticky: frame aborted by TIMEOUT
// BEHAVIOUR
// - Reset (rst_n low at clk edge): all outputs 0, state IDLE, counters 0, snapshot/result shadows 0.
// - Edge detect: edge = sample_clk & ~sample_clk_q (sample_clk_q registered, reset 0).
// - FSM IDLE: on edge, snapshot ch_in/ch_g/ch_res, idx=0, rcnt=0, wdog=0 -> ISSUE.
// - ISSUE: core_valid=1, core_ch=idx, data from snapshot (registered, stable while stalled). On valid&ready: idx++; accept of idx=N_CH-1 -> DRAIN, core_valid=0 next cycle. core_valid never drops without acceptance.
// - Results counted in ISSUE and DRAIN: core_out_valid with core_out_ch < N_CH writes result shadow[core_out_ch], rcnt++; tags >= N_CH ignored, not counted. Results in IDLE ignored.
// - DRAIN: when rcnt==N_CH -> commit all shadows to ch_out at once, pulse frame_done (visible next cycle), -> IDLE.
// - Edge in the commit cycle is accepted: snapshot taken, next state ISSUE, no overrun.
// - Edge in any other busy cycle: dropped, overrun<=1; current frame unaffected.
// - Watchdog wdog counts every busy cycle; at wdog==TIMEOUT-1 without commit: -> IDLE, core_valid<=0, timeout_err<=1, ch_out unchanged, frame_done not pulsed.
// - Latency (core_ready=1, core latency L): edge seen at cycle E -> issues E+1..E+N_CH -> ch_out/frame_done at E+N_CH+L+2.
// - rst_n low mid-frame: abort immediately, all outputs to reset values next cycle.
// - No arithmetic on samples; data passes bit-exact.
// CONFIGURATION
// - FILTER_SCHED_LATENCY_EN defined: adds output frame_cycles [15:0]; on each commit loads cycles from edge cycle E to commit (E+N_CH+L+2 -> N_CH+L+2), saturating at 16'hFFFF; reset 0; held on timeout.
// - Undefined: port and counter absent; all other behaviour identical.
// TESTING
// - N_CH=4, L=3, ready=1, ch_in={4000,-3000,2000,-1000} identity core -> ch_out equals inputs at E+9, one frame_done pulse, frame_cycles=9.
// - core_ready toggles 1,0,0,1 per cycle -> core_ch/core_sample stable while stalled, 4 issues in order 0..3, correct commit.
// - Core returns results out of order (3,1,0,2) -> each lands in its own ch_out slot, commit once after 4th.
// - Second edge 2 cycles after first -> overrun=1, single frame_done; edge exactly in commit cycle -> next frame starts, overrun stays 0.
// - Core never asserts core_out_valid, TIMEOUT=64 -> abort at wdog 63, timeout_err=1, ch_out keeps prior frame, busy=0.
// - rst_n low during DRAIN -> next cycle all outputs 0, late core_out_valid ignored, next edge runs a clean frame.

Source files
------------

// File: rtl/filter_voice_scheduler.sv
// filter_voice_scheduler: shares one pipelined filter core among N_CH channels.
// Each sample_clk rising edge snapshots every channel, issues the snapshot to
// the core in channel order, gathers tagged results and commits all outputs
// in one cycle. Data passes bit-exact; no arithmetic on samples.
// Optional feature macro: FILTER_SCHED_LATENCY_EN adds frame_cycles, the
// number of cycles from the accepted edge to the commit (saturating).
module filter_voice_scheduler #(
  parameter  int W       = 16,
  parameter  int N_CH    = 4,
  parameter  int TIMEOUT = 1024,
  localparam int CHW     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_clk,
  input  logic [N_CH*W-1:0] ch_in,
  input  logic [N_CH*W-1:0] ch_g,
  input  logic [N_CH*W-1:0] ch_res,
  output logic              core_valid,
  input  logic              core_ready,
  output logic [CHW-1:0]    core_ch,
  output logic [W-1:0]      core_sample,
  output logic [W-1:0]      core_g,
  output logic [W-1:0]      core_res,
  input  logic              core_out_valid,
  input  logic [CHW-1:0]    core_out_ch,
  input  logic [W-1:0]      core_out,
  output logic [N_CH*W-1:0] ch_out,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
`ifdef FILTER_SCHED_LATENCY_EN
  ,
  output logic [15:0]       frame_cycles
`endif
);

  localparam int RCW = $clog2(N_CH + 1);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RCW-1:0] RCNT_FULL = RCW'(N_CH);
  localparam logic [CHW:0]   TAG_LIMIT = (CHW+1)'(N_CH);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
  localparam logic [CHW-1:0] IDX_LAST  = CHW'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            r_state;
  logic              r_sclk_q;
  logic [N_CH*W-1:0] r_snap_in;
  logic [N_CH*W-1:0] r_snap_g;
  logic [N_CH*W-1:0] r_snap_res;
  logic [N_CH*W-1:0] r_shadow;
  logic [CHW-1:0]    r_idx;
  logic [RCW-1:0]    r_rcnt;
  logic [WDW-1:0]    r_wdog;

  logic              w_edge;
  logic              w_busy;
  logic              w_commit;
  logic              w_timeout;
  logic              w_accept;
  logic              w_result;
  logic              w_start;
  logic [CHW-1:0]    w_idx_nxt;

  assign w_edge    = sample_clk & ~r_sclk_q;
  assign w_busy    = (r_state != S_IDLE);
  assign w_commit  = (r_state == S_DRAIN) && (r_rcnt == RCNT_FULL);
  assign w_timeout = w_busy && !w_commit && (r_wdog == WDOG_LAST);
  assign w_accept  = (r_state == S_ISSUE) && core_valid && core_ready;
  // A full result count blocks further writes so a stray extra strobe cannot
  // push the count past the commit condition.
  assign w_result  = w_busy && core_out_valid && ({1'b0, core_out_ch} < TAG_LIMIT)
                     && (r_rcnt != RCNT_FULL);
  // The commit cycle doubles as an idle cycle for edge acceptance.
  assign w_start   = w_edge && ((r_state == S_IDLE) || w_commit);
  assign w_idx_nxt = r_idx + 1'b1;

  assign core_ch = r_idx;
  assign busy    = w_busy;

  // Frame sequencer: snapshot, in-order issue, result collection, commit/abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sclk_q    <= 1'b0;
      r_snap_in   <= '0;
      r_snap_g    <= '0;
      r_snap_res  <= '0;
      r_shadow    <= '0;
      r_idx       <= '0;
      r_rcnt      <= '0;
      r_wdog      <= '0;
      core_valid  <= 1'b0;
      core_sample <= '0;
      core_g      <= '0;
      core_res    <= '0;
      ch_out      <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_sclk_q   <= sample_clk;
      frame_done <= 1'b0;

      if (w_result) begin
        r_shadow[core_out_ch*W +: W] <= core_out;
        r_rcnt                       <= r_rcnt + 1'b1;
      end

      if (w_busy) begin
        r_wdog <= r_wdog + 1'b1;
      end

      if (w_edge && w_busy && !w_commit) begin
        overrun <= 1'b1;
      end

      unique case (r_state)
        S_ISSUE: begin
          if (w_timeout) begin
            r_state     <= S_IDLE;
            core_valid  <= 1'b0;
            timeout_err <= 1'b1;
          end else if (w_accept) begin
            if (r_idx == IDX_LAST) begin
              r_state    <= S_DRAIN;
              core_valid <= 1'b0;
            end else begin
              r_idx       <= w_idx_nxt;
              core_sample <= r_snap_in[w_idx_nxt*W +: W];
              core_g      <= r_snap_g[w_idx_nxt*W +: W];
              core_res    <= r_snap_res[w_idx_nxt*W +: W];
            end
          end
        end
        S_DRAIN: begin
          if (w_commit) begin
            ch_out     <= r_shadow;
            frame_done <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase

      // Placed last so a start in the commit cycle overrides the return to idle.
      if (w_start) begin
        r_state     <= S_ISSUE;
        r_snap_in   <= ch_in;
        r_snap_g    <= ch_g;
        r_snap_res  <= ch_res;
        r_idx       <= '0;
        r_rcnt      <= '0;
        r_wdog      <= '0;
        core_valid  <= 1'b1;
        core_sample <= ch_in[W-1:0];
        core_g      <= ch_g[W-1:0];
        core_res    <= ch_res[W-1:0];
      end
    end
  end

`ifdef FILTER_SCHED_LATENCY_EN
  logic [15:0] r_fc;

  // Edge-to-commit cycle counter; the edge cycle itself counts as cycle 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fc         <= '0;
      frame_cycles <= '0;
    end else begin
      if (w_commit) begin
        frame_cycles <= (r_fc == 16'hFFFF) ? r_fc : r_fc + 16'd1;
      end
      if (w_start) begin
        r_fc <= 16'd1;
      end else if (w_busy && (r_fc != 16'hFFFF)) begin
        r_fc <= r_fc + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_filter_voice_scheduler.sv
// Testbench for filter_voice_scheduler with a behavioural core model
// (identity data, latency L, optional reordering or silence).
module tb_filter_voice_scheduler;
  localparam int W       = 16;
  localparam int N_CH    = 4;
  localparam int CHW     = 2;
  localparam int TIMEOUT = 64;
  localparam int L       = 3;
  localparam int LAT     = N_CH + L + 2;

  logic              clk         = 1'b0;
  logic              rst_n       = 1'b0;
  logic              sample_clk  = 1'b0;
  logic [N_CH*W-1:0] ch_in       = '0;
  logic [N_CH*W-1:0] ch_g        = '0;
  logic [N_CH*W-1:0] ch_res      = '0;
  logic              core_valid;
  logic              core_ready  = 1'b0;
  logic [CHW-1:0]    core_ch;
  logic [W-1:0]      core_sample;
  logic [W-1:0]      core_g;
  logic [W-1:0]      core_res;
  logic              core_out_valid = 1'b0;
  logic [CHW-1:0]    core_out_ch    = '0;
  logic [W-1:0]      core_out       = '0;
  logic [N_CH*W-1:0] ch_out;
  logic              frame_done;
  logic              busy;
  logic              overrun;
  logic              timeout_err;
`ifdef FILTER_SCHED_LATENCY_EN
  logic [15:0]       frame_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  filter_voice_scheduler #(.W(W), .N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk),
    .ch_in(ch_in), .ch_g(ch_g), .ch_res(ch_res),
    .core_valid(core_valid), .core_ready(core_ready), .core_ch(core_ch),
    .core_sample(core_sample), .core_g(core_g), .core_res(core_res),
    .core_out_valid(core_out_valid), .core_out_ch(core_out_ch), .core_out(core_out),
    .ch_out(ch_out), .frame_done(frame_done), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
`ifdef FILTER_SCHED_LATENCY_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  // ---------------- core model ----------------
  typedef enum int {M_PIPE, M_OOO, M_MUTE} mode_t;
  typedef struct { int unsigned due; logic [CHW-1:0] ch; logic [W-1:0] d; } job_t;

  mode_t       core_mode  = M_PIPE;
  logic        core_clear = 1'b0;
  int unsigned cyc        = 0;
  job_t        pipe_q[$];
  job_t        core_j;
  logic [W-1:0] hold [N_CH];
  int unsigned hold_cnt   = 0;
  int unsigned emit_idx   = 0;
  int unsigned ooo_order [N_CH] = '{3, 1, 0, 2};

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (core_clear) begin
        pipe_q.delete();
        hold_cnt = 0;
        emit_idx = 0;
        core_out_valid <= 1'b0;
      end else begin
        if (core_valid && core_ready) begin
          if (core_mode == M_PIPE) begin
            pipe_q.push_back('{cyc + L - 1, core_ch, core_sample});
          end else if (core_mode == M_OOO) begin
            hold[core_ch] = core_sample;
            hold_cnt++;
          end
        end
        core_out_valid <= 1'b0;
        if (core_mode == M_PIPE && pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
          core_j = pipe_q.pop_front();
          core_out_valid <= 1'b1;
          core_out_ch    <= core_j.ch;
          core_out       <= core_j.d;
        end else if (core_mode == M_OOO && hold_cnt == N_CH && emit_idx < N_CH) begin
          core_out_valid <= 1'b1;
          core_out_ch    <= CHW'(ooo_order[emit_idx]);
          core_out       <= hold[ooo_order[emit_idx]];
          emit_idx++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [CHW-1:0] ch; logic [W-1:0] s; logic [W-1:0] g; logic [W-1:0] r; } issue_t;
  issue_t            exp_issue_q[$];
  logic [N_CH*W-1:0] exp_frame_q[$];

  bit     acc;
  issue_t acc_v;

  function automatic logic [N_CH*W-1:0] mk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Advance one cycle, recording whether an issue handshake completes at the edge.
  task automatic tick();
    acc   = core_valid && core_ready;
    acc_v = '{core_ch, core_sample, core_g, core_res};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic core_setup(input mode_t m);
    core_mode  = m;
    core_clear = 1'b1;
    tick();
    core_clear = 1'b0;
  endtask

  task automatic drive_edge(input logic [N_CH*W-1:0] din, input logic [N_CH*W-1:0] dg,
                            input logic [N_CH*W-1:0] dr, input bit expect_commit);
    ch_in = din; ch_g = dg; ch_res = dr;
    sample_clk = 1'b1;
    for (int k = 0; k < N_CH; k++)
      exp_issue_q.push_back('{CHW'(k), din[k*W +: W], dg[k*W +: W], dr[k*W +: W]});
    if (expect_commit) exp_frame_q.push_back(din);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; sample_clk = 1'b0; core_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({core_valid, frame_done, busy, overrun, timeout_err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 00000", {core_valid, frame_done, busy, overrun, timeout_err});
    end
    n_cmp++;
    if (ch_out !== '0) begin n_bad++; $display("FAIL reset_ch_out got %h want 0", ch_out); end
    n_cmp++;
    if ({core_ch, core_sample, core_g, core_res} !== '0) begin
      n_bad++; $display("FAIL reset_core_bus got %h want 0", {core_ch, core_sample, core_g, core_res});
    end
`ifdef FILTER_SCHED_LATENCY_EN
    n_cmp++;
    if (frame_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cycles got %0d want 0", frame_cycles); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    issue_t e;
    logic [N_CH*W-1:0] d, ef;
    int done_rel, pulses, first_iss, last_iss;
    core_setup(M_PIPE);
    core_ready = 1'b1;
    d = mk(4000, -3000, 2000, -1000);
    drive_edge(d, mk(100, 200, 300, 400), mk(-5, -6, -7, -8), 1'b1);
    tick();
    sample_clk = 1'b0;
    ch_in = ~d;
    done_rel = 0; pulses = 0; first_iss = 0; last_iss = 0;
    for (int rel = 1; rel <= 20; rel++) begin
      if (frame_done) begin
        pulses++;
        if (done_rel == 0) begin
          done_rel = rel;
          ef = (exp_frame_q.size() != 0) ? exp_frame_q.pop_front() : 'x;
          n_cmp++;
          if (ch_out !== ef) begin n_bad++; $display("FAIL basic_ch_out got %h want %h", ch_out, ef); end
`ifdef FILTER_SCHED_LATENCY_EN
          n_cmp++;
          if (frame_cycles !== 16'(LAT)) begin n_bad++; $display("FAIL basic_frame_cycles got %0d want %0d", frame_cycles, LAT); end
`endif
        end
      end
      tick();
      if (acc) begin
        if (first_iss == 0) first_iss = rel;
        last_iss = rel;
        e = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : 'x;
        n_cmp++;
        if (acc_v !== e) begin n_bad++; $display("FAIL basic_issue got %h want %h", acc_v, e); end
      end
    end
    n_cmp++;
    if (done_rel != LAT) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", done_rel, LAT); end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL basic_pulses got %0d want 1", pulses); end
    n_cmp++;
    if (first_iss != 1 || last_iss != N_CH) begin
      n_bad++; $display("FAIL basic_issue_cycles got %0d..%0d want 1..%0d", first_iss, last_iss, N_CH);
    end
    n_cmp++;
    if (busy !== 1'b0 || exp_issue_q.size() != 0) begin
      n_bad++; $display("FAIL basic_idle got busy=%b pending=%0d want 0/0", busy, exp_issue_q.size());
    end
  endtask

  task automatic test_stall();
    issue_t e, held;
    logic [N_CH*W-1:0] d, ef;
    bit stalled;
    int pulses;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    core_setup(M_PIPE);
    d = mk(11, -22, 33, -44);
    drive_edge(d, mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b1);
    tick();
    sample_clk = 1'b0;
    stalled = 1'b0; pulses = 0; held = '0;
    for (int rel = 1; rel <= 30; rel++) begin
      core_ready = pat[(rel - 1) % 4];
      if (stalled) begin
        n_cmp++;
        if ({core_valid, core_ch, core_sample, core_g, core_res} !== {1'b1, held}) begin
          n_bad++; $display("FAIL stall_hold got %h want %h", {core_ch, core_sample, core_g, core_res}, held);
        end
      end
      stalled = core_valid && !core_ready;
      held    = '{core_ch, core_sample, core_g, core_res};
      if (frame_done) begin
        pulses++;
        ef = (exp_frame_q.size() != 0) ? exp_frame_q.pop_front() : 'x;
        n_cmp++;
        if (ch_out !== ef) begin n_bad++; $display("FAIL stall_ch_out got %h want %h", ch_out, ef); end
      end
      tick();
      if (acc) begin
        e = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : 'x;
        n_cmp++;
        if (acc_v !== e) begin n_bad++; $display("FAIL stall_issue got %h want %h", acc_v, e); end
      end
    end
    core_ready = 1'b1;
    n_cmp++;
    if (pulses != 1 || exp_issue_q.size() != 0) begin
      n_bad++; $display("FAIL stall_complete got pulses=%0d pending=%0d want 1/0", pulses, exp_issue_q.size());
    end
  endtask

  task automatic test_ooo();
    issue_t e;
    logic [N_CH*W-1:0] d, ef;
    int pulses, done_rel;
    core_setup(M_OOO);
    core_ready = 1'b1;
    d = mk(-32768, 32767, 1234, -4321);
    drive_edge(d, mk(9, 9, 9, 9), mk(0, 0, 0, 0), 1'b1);
    tick();
    sample_clk = 1'b0;
    pulses = 0; done_rel = 0;
    for (int rel = 1; rel <= 25; rel++) begin
      if (frame_done) begin
        pulses++;
        if (done_rel == 0) done_rel = rel;
        ef = (exp_frame_q.size() != 0) ? exp_frame_q.pop_front() : 'x;
        n_cmp++;
        if (ch_out !== ef) begin n_bad++; $display("FAIL ooo_ch_out got %h want %h", ch_out, ef); end
      end
      tick();
      if (acc) begin
        e = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : 'x;
        n_cmp++;
        if (acc_v !== e) begin n_bad++; $display("FAIL ooo_issue got %h want %h", acc_v, e); end
      end
    end
    n_cmp++;
    if (pulses != 1 || done_rel != 2 * N_CH + 2) begin
      n_bad++; $display("FAIL ooo_commit got pulses=%0d at %0d want 1 at %0d", pulses, done_rel, 2 * N_CH + 2);
    end
  endtask

  task automatic test_overrun();
    issue_t e;
    logic [N_CH*W-1:0] d, ef;
    int pulses, done_rel;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    core_setup(M_PIPE);
    core_ready = 1'b1;
    d = mk(7, 8, 9, 10);
    drive_edge(d, mk(1, 1, 1, 1), mk(2, 2, 2, 2), 1'b1);
    tick();
    pulses = 0; done_rel = 0;
    for (int rel = 1; rel <= 25; rel++) begin
      if (rel == 2) begin
        sample_clk = 1'b1;
        ch_in = mk(-1, -1, -1, -1);
      end else begin
        sample_clk = 1'b0;
      end
      if (frame_done) begin
        pulses++;
        if (done_rel == 0) done_rel = rel;
        ef = (exp_frame_q.size() != 0) ? exp_frame_q.pop_front() : 'x;
        n_cmp++;
        if (ch_out !== ef) begin n_bad++; $display("FAIL overrun_ch_out got %h want %h", ch_out, ef); end
      end
      tick();
      if (acc) begin
        e = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : 'x;
        n_cmp++;
        if (acc_v !== e) begin n_bad++; $display("FAIL overrun_issue got %h want %h", acc_v, e); end
      end
    end
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_flag got %b want 1", overrun); end
    n_cmp++;
    if (pulses != 1 || done_rel != LAT) begin
      n_bad++; $display("FAIL overrun_frames got %0d at %0d want 1 at %0d", pulses, done_rel, LAT);
    end
  endtask

  task automatic test_back_to_back();
    issue_t e;
    logic [N_CH*W-1:0] ef;
    int pulses;
    int done_at [2];
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    core_setup(M_PIPE);
    core_ready = 1'b1;
    drive_edge(mk(100, 101, 102, 103), mk(3, 3, 3, 3), mk(4, 4, 4, 4), 1'b1);
    tick();
    pulses = 0; done_at = '{0, 0};
    for (int rel = 1; rel <= 30; rel++) begin
      if (rel == LAT - 1) drive_edge(mk(-200, -201, -202, -203), mk(5, 6, 7, 8), mk(8, 7, 6, 5), 1'b1);
      else sample_clk = 1'b0;
      if (frame_done) begin
        if (pulses < 2) done_at[pulses] = rel;
        pulses++;
        ef = (exp_frame_q.size() != 0) ? exp_frame_q.pop_front() : 'x;
        n_cmp++;
        if (ch_out !== ef) begin n_bad++; $display("FAIL b2b_ch_out got %h want %h", ch_out, ef); end
`ifdef FILTER_SCHED_LATENCY_EN
        n_cmp++;
        if (frame_cycles !== 16'(LAT)) begin n_bad++; $display("FAIL b2b_frame_cycles got %0d want %0d", frame_cycles, LAT); end
`endif
      end
      tick();
      if (acc) begin
        e = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : 'x;
        n_cmp++;
        if (acc_v !== e) begin n_bad++; $display("FAIL b2b_issue got %h want %h", acc_v, e); end
      end
    end
    n_cmp++;
    if (pulses != 2 || done_at[0] != LAT || done_at[1] != 2 * LAT - 1) begin
      n_bad++; $display("FAIL b2b_frames got %0d at %0d,%0d want 2 at %0d,%0d",
                        pulses, done_at[0], done_at[1], LAT, 2 * LAT - 1);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", overrun); end
  endtask

  task automatic test_timeout();
    issue_t e;
    logic [N_CH*W-1:0] prev_out;
    int pulses;
`ifdef FILTER_SCHED_LATENCY_EN
    logic [15:0] prev_fc;
    prev_fc = frame_cycles;
`endif
    prev_out = ch_out;
    core_setup(M_MUTE);
    core_ready = 1'b1;
    drive_edge(mk(55, 66, 77, 88), mk(0, 0, 0, 0), mk(1, 1, 1, 1), 1'b0);
    tick();
    sample_clk = 1'b0;
    pulses = 0;
    for (int rel = 1; rel <= TIMEOUT + 4; rel++) begin
      if (frame_done) pulses++;
      if (rel == TIMEOUT) begin
        n_cmp++;
        if ({busy, timeout_err} !== 2'b10) begin
          n_bad++; $display("FAIL timeout_before got busy/err=%b want 10", {busy, timeout_err});
        end
      end
      if (rel == TIMEOUT + 1) begin
        n_cmp++;
        if ({busy, timeout_err, core_valid} !== 3'b010) begin
          n_bad++; $display("FAIL timeout_abort got busy/err/valid=%b want 010", {busy, timeout_err, core_valid});
        end
      end
      tick();
      if (acc) begin
        e = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : 'x;
        n_cmp++;
        if (acc_v !== e) begin n_bad++; $display("FAIL timeout_issue got %h want %h", acc_v, e); end
      end
    end
    n_cmp++;
    if (pulses != 0 || ch_out !== prev_out) begin
      n_bad++; $display("FAIL timeout_hold got pulses=%0d ch_out=%h want 0 / %h", pulses, ch_out, prev_out);
    end
`ifdef FILTER_SCHED_LATENCY_EN
    n_cmp++;
    if (frame_cycles !== prev_fc) begin n_bad++; $display("FAIL timeout_frame_cycles got %0d want %0d", frame_cycles, prev_fc); end
`endif
  endtask

  task automatic test_reset_drain();
    issue_t e;
    logic [N_CH*W-1:0] ef;
    int pulses, done_rel;
    core_setup(M_PIPE);
    core_ready = 1'b1;
    drive_edge(mk(1, 2, 3, 4), mk(5, 5, 5, 5), mk(6, 6, 6, 6), 1'b0);
    tick();
    sample_clk = 1'b0;
    pulses = 0;
    for (int rel = 1; rel <= 14; rel++) begin
      if (rel == 6) rst_n = 1'b0;
      if (rel == 7) begin
        rst_n = 1'b1;
        n_cmp++;
        if ({core_valid, busy, frame_done, overrun, timeout_err, ch_out} !== '0) begin
          n_bad++; $display("FAIL rstdrain_outputs got %b/%h want all 0",
                            {core_valid, busy, frame_done, overrun, timeout_err}, ch_out);
        end
`ifdef FILTER_SCHED_LATENCY_EN
        n_cmp++;
        if (frame_cycles !== 16'd0) begin n_bad++; $display("FAIL rstdrain_frame_cycles got %0d want 0", frame_cycles); end
`endif
      end
      if (frame_done) pulses++;
      tick();
      if (acc) begin
        e = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : 'x;
        n_cmp++;
        if (acc_v !== e) begin n_bad++; $display("FAIL rstdrain_issue got %h want %h", acc_v, e); end
      end
    end
    n_cmp++;
    if (pulses != 0 || ch_out !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rstdrain_late got pulses=%0d busy=%b ch_out=%h want 0/0/0", pulses, busy, ch_out);
    end
    drive_edge(mk(-9, 8, -7, 6), mk(2, 3, 4, 5), mk(6, 7, 8, 9), 1'b1);
    tick();
    sample_clk = 1'b0;
    done_rel = 0;
    for (int rel = 1; rel <= 20; rel++) begin
      if (frame_done && done_rel == 0) begin
        done_rel = rel;
        ef = (exp_frame_q.size() != 0) ? exp_frame_q.pop_front() : 'x;
        n_cmp++;
        if (ch_out !== ef) begin n_bad++; $display("FAIL rstdrain_clean_out got %h want %h", ch_out, ef); end
      end
      tick();
      if (acc) begin
        e = (exp_issue_q.size() != 0) ? exp_issue_q.pop_front() : 'x;
        n_cmp++;
        if (acc_v !== e) begin n_bad++; $display("FAIL rstdrain_clean_issue got %h want %h", acc_v, e); end
      end
    end
    n_cmp++;
    if (done_rel != LAT) begin n_bad++; $display("FAIL rstdrain_clean_latency got %0d want %0d", done_rel, LAT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ooo();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
